serial_magnitude_comparator: RTL and testbench

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/serial_magnitude_comparator.sv | 129 ++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first slice-serial magnitude comparator (optional SERIAL_CMP_EARLY_EXIT_EN)
module serial_magnitude_comparator #(
    parameter int WIDTH  = 16,
    parameter int SLICE  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             decided;
    logic             last;

    // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
    always_comb begin
        sl_a = sh_a[WIDTH-1 -: SLICE];
        sl_b = sh_b[WIDTH-1 -: SLICE];
        if (SIGNED != 0 && cnt == CW'(N - 1)) begin
            sl_a[SLICE-1] = ~sl_a[SLICE-1];
            sl_b[SLICE-1] = ~sl_b[SLICE-1];
        end
    end

    assign slice_gt = (sl_a > sl_b);
    assign slice_lt = (sl_a < sl_b);
    assign decided  = gt | lt;
    assign last     = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (last || (!decided && (slice_gt || slice_lt))) begin
                    state_nx = S_DONE;
                end
`else
                if (last) begin
                    state_nx = S_DONE;
                end
`endif
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_a <= a;
                        sh_b <= b;
                        cnt  <= CW'(N - 1);
                        gt   <= 1'b0;
                        eq   <= 1'b0;
                        lt   <= 1'b0;
                    end
                end
                S_RUN: begin
                    sh_a <= sh_a << SLICE;
                    sh_b <= sh_b << SLICE;
                    if (!last) begin
                        cnt <= cnt - 1'b1;
                    end
                    // Only the first differing slice decides; later slices are don't-care.
                    if (!decided) begin
                        gt <= slice_gt;
                        lt <= slice_lt;
                        if (last && !slice_gt && !slice_lt) begin
                            eq <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for serial_magnitude_comparator, unsigned and signed instances
module tb_serial_magnitude_comparator;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, gt, eq, lt;
    logic        busy_s, done_s, gt_s, eq_s, lt_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_prev = 0;
    int done_last = 0;

    typedef struct {
        logic [2:0] res;
        int         acc;
        int         lat;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];

    serial_magnitude_comparator #(.WIDTH(16), .SLICE(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    serial_magnitude_comparator #(.WIDTH(16), .SLICE(4), .SIGNED(1)) u_sdut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .gt(gt_s), .eq(eq_s), .lt(lt_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks result and latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                done_prev = done_last;
                done_last = cyc;
                chk("u_busy_at_done", {31'd0, busy}, 32'd0);
                if (q_u.size() == 0) begin
                    chk("u_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q_u.pop_front();
                    chk("u_result", {29'd0, gt, eq, lt}, {29'd0, e.res});
                    chk("u_latency", cyc - e.acc + 1, e.lat);
                end
            end
            if (done_s) begin
                if (q_s.size() == 0) begin
                    chk("s_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q_s.pop_front();
                    chk("s_result", {29'd0, gt_s, eq_s, lt_s}, {29'd0, e.res});
                    chk("s_latency", cyc - e.acc + 1, e.lat);
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || done || busy_s || done_s) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // k: 1-based index of the first differing slice from the MSB (N when equal).
    task automatic do_cmp(input logic [15:0] va, input logic [15:0] vb,
                          input logic [2:0] eu, input logic [2:0] es,
                          input int k, input bit track);
        exp_t e;
        wait_idle();
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            e.acc = cyc;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            e.lat = k + 1;
`else
            e.lat = N + 1;
`endif
            e.res = eu;
            q_u.push_back(e);
            e.res = es;
            q_s.push_back(e);
        end
    endtask

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs_u", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        chk("rst_outputs_s", {27'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 32'd0);
        rst = 1'b0;

        do_cmp(16'hA5A5, 16'hA5A5, EQ, EQ, 4, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("eq_hold_u", {29'd0, gt, eq, lt}, {29'd0, EQ});
        chk("eq_hold_s", {29'd0, gt_s, eq_s, lt_s}, {29'd0, EQ});

        do_cmp(16'h8000, 16'h7FFF, GT, LT, 1, 1'b1);
        do_cmp(16'h0001, 16'h0002, LT, LT, 4, 1'b1);
        do_cmp(16'hFFFF, 16'h0000, GT, LT, 1, 1'b1);

        // Start pulse and operand change mid-RUN must not disturb the compare in flight.
        do_cmp(16'h00F0, 16'h00E0, GT, GT, 3, 1'b1);
        @(negedge clk);
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        start = 1'b1;
        a = 16'h0000;
        b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        a = 16'h0F0F;
        b = 16'hF0F0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("dropped_start_q", q_u.size(), 32'd0);

        do_cmp(16'h7000, 16'h7001, LT, LT, 4, 1'b1);
        do_cmp(16'h1234, 16'h1200, GT, GT, 3, 1'b1);
        wait_idle();
`ifndef SERIAL_CMP_EARLY_EXIT_EN
        chk("b2b_spacing", done_last - done_prev, N + 2);
`endif

        // Reset mid-RUN: everything clears, no done pulse afterwards.
        do_cmp(16'h1234, 16'h1235, LT, LT, 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_rst_u", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        chk("midrun_rst_s", {27'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, busy_s}, 32'd0);

        do_cmp(16'h0010, 16'h0001, GT, GT, 3, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("q_u_empty", q_u.size(), 32'd0);
        chk("q_s_empty", q_s.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
